// File: rtl/fwd_ctrl_unit.sv
// fwd_ctrl_unit: EX-stage operand forwarding selects, load-use stall and stall counter
// for the 16-bit pipelined datapath.
module fwd_ctrl_unit #(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_id_valid,
  input  logic [REG_AW-1:0] in_id_rs1,
  input  logic              in_id_rs1_used,
  input  logic [REG_AW-1:0] in_id_rs2,
  input  logic              in_id_rs2_used,
  input  logic [REG_AW-1:0] in_id_rd,
  input  logic              in_id_wr_en,
  input  logic              in_id_is_load,
  input  logic              in_flush,
  input  logic              in_cnt_clr,
  output logic [1:0]        out_cntrl_m2,
  output logic [1:0]        out_cntrl_m3,
  output logic              out_stall,
  output logic              out_ex_valid,
  output logic [CNT_W-1:0]  out_stall_cnt
);
  localparam logic [1:0] SEL_RF  = 2'b11;
  localparam logic [1:0] SEL_ALU = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b00;
  logic              ex_v_q, ex_we_q, ex_ld_q, mem_v_q, mem_we_q;
  logic [REG_AW-1:0] ex_rd_q, mem_rd_q;
  logic [1:0]        m2_q, m3_q, m2_d, m3_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ex_hit1, ex_hit2, mem_hit1, mem_hit2, advance;
  // r0 is hardwired zero, so a tag of 0 never counts as a producer
  always_comb begin
    ex_hit1   = in_id_rs1_used && ex_v_q && ex_we_q && ex_rd_q != '0 && ex_rd_q == in_id_rs1;
    ex_hit2   = in_id_rs2_used && ex_v_q && ex_we_q && ex_rd_q != '0 && ex_rd_q == in_id_rs2;
    mem_hit1  = in_id_rs1_used && mem_v_q && mem_we_q && mem_rd_q != '0 && mem_rd_q == in_id_rs1;
    mem_hit2  = in_id_rs2_used && mem_v_q && mem_we_q && mem_rd_q != '0 && mem_rd_q == in_id_rs2;
    out_stall = in_id_valid && !in_flush && ex_ld_q && (ex_hit1 || ex_hit2);
    advance   = in_id_valid && !out_stall && !in_flush;
    m2_d      = !advance ? SEL_RF : ex_hit1 ? SEL_ALU : mem_hit1 ? SEL_WB : SEL_RF;
    m3_d      = !advance ? SEL_RF : ex_hit2 ? SEL_ALU : mem_hit2 ? SEL_WB : SEL_RF;
    cnt_d     = in_cnt_clr ? '0 : (out_stall && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      ex_v_q   <= 1'b0;
      ex_we_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      ex_rd_q  <= '0;
      mem_v_q  <= 1'b0;
      mem_we_q <= 1'b0;
      mem_rd_q <= '0;
      m2_q     <= SEL_RF;
      m3_q     <= SEL_RF;
      cnt_q    <= '0;
    end else begin
      ex_v_q   <= advance;
      ex_we_q  <= in_id_wr_en;
      ex_ld_q  <= advance && in_id_is_load;
      ex_rd_q  <= in_id_rd;
      mem_v_q  <= ex_v_q && !in_flush;
      mem_we_q <= ex_we_q;
      mem_rd_q <= ex_rd_q;
      m2_q     <= m2_d;
      m3_q     <= m3_d;
      cnt_q    <= cnt_d;
    end
  end
  assign out_cntrl_m2  = m2_q;
  assign out_cntrl_m3  = m3_q;
  assign out_ex_valid  = ex_v_q;
  assign out_stall_cnt = cnt_q;
endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// tb_fwd_ctrl_unit: directed vector table, reset and saturation sequences, then random
// traffic against a pipeline-occupancy reference model.
module tb_fwd_ctrl_unit;
  logic       clk = 1'b0, rst_n;
  logic       id_valid, u1, u2, we, ld, flush, cnt_clr;
  logic [3:0] rs1, rs2, rd;
  logic [1:0] m2, m3, s_m2, s_m3;
  logic       stall, exv, s_stall, s_exv;
  logic [15:0] cnt;
  logic [3:0]  s_cnt;
  always #5 clk = ~clk;

  fwd_ctrl_unit dut (
    .in_clk(clk), .in_rst_n(rst_n), .in_id_valid(id_valid), .in_id_rs1(rs1),
    .in_id_rs1_used(u1), .in_id_rs2(rs2), .in_id_rs2_used(u2), .in_id_rd(rd),
    .in_id_wr_en(we), .in_id_is_load(ld), .in_flush(flush), .in_cnt_clr(cnt_clr),
    .out_cntrl_m2(m2), .out_cntrl_m3(m3), .out_stall(stall), .out_ex_valid(exv),
    .out_stall_cnt(cnt)
  );
  // narrow-counter copy so saturation is reachable in a short run
  fwd_ctrl_unit #(.CNT_W(4)) dut_s (
    .in_clk(clk), .in_rst_n(rst_n), .in_id_valid(id_valid), .in_id_rs1(rs1),
    .in_id_rs1_used(u1), .in_id_rs2(rs2), .in_id_rs2_used(u2), .in_id_rd(rd),
    .in_id_wr_en(we), .in_id_is_load(ld), .in_flush(flush), .in_cnt_clr(cnt_clr),
    .out_cntrl_m2(s_m2), .out_cntrl_m3(s_m3), .out_stall(s_stall), .out_ex_valid(s_exv),
    .out_stall_cnt(s_cnt)
  );

  typedef struct {logic v; logic [3:0] rd; logic we, ld;} ins_t;
  typedef struct {
    logic v; logic [3:0] rs1; logic u1; logic [3:0] rs2; logic u2; logic [3:0] rd;
    logic we, ld, fl, e_st; logic [1:0] e_m2, e_m3; logic e_xv; int e_cnt;
  } vec_t;

  ins_t m_ex, m_mem;
  logic [1:0] m_m2, m_m3;
  int m_cnt, total = 0, bad = 0;
  logic act_stall;
  vec_t tbl[22];
  localparam ins_t NONE = '{1'b0, 4'd0, 1'b0, 1'b0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic wr(input ins_t p, input logic [3:0] rs, input logic used);
    return used && p.v && p.we && p.rd != 4'd0 && p.rd == rs;
  endfunction

  // youngest producer wins: EX result first, then the writeback value
  function automatic logic [1:0] pick(input logic [3:0] rs, input logic used);
    if (wr(m_ex, rs, used)) return 2'b01;
    if (wr(m_mem, rs, used)) return 2'b00;
    return 2'b11;
  endfunction

  function automatic logic model_stall();
    return id_valid && !flush && m_ex.v && m_ex.ld && (wr(m_ex, rs1, u1) || wr(m_ex, rs2, u2));
  endfunction

  task automatic model_reset();
    m_ex = NONE; m_mem = NONE; m_m2 = 2'b11; m_m3 = 2'b11; m_cnt = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_m2"}, m2, m_m2);
    chk({tag, "_m3"}, m3, m_m3);
    chk({tag, "_exv"}, exv, m_ex.v);
    chk({tag, "_cnt"}, cnt, m_cnt > 65535 ? 65535 : m_cnt);
    chk({tag, "_cnt_s"}, s_cnt, m_cnt > 15 ? 15 : m_cnt);
    chk({tag, "_m2_s"}, s_m2, m_m2);
  endtask

  task automatic tick();
    logic st, adv;
    #1;
    st = model_stall();
    act_stall = stall;
    chk("stall", stall, st);
    chk("stall_s", s_stall, st);
    @(posedge clk);
    adv = id_valid && !st && !flush;
    m_m2 = adv ? pick(rs1, u1) : 2'b11;
    m_m3 = adv ? pick(rs2, u2) : 2'b11;
    m_mem = flush ? NONE : m_ex;
    m_ex = adv ? '{1'b1, rd, we, ld} : NONE;
    m_cnt = cnt_clr ? 0 : m_cnt + int'(st);
    #1;
    check_regs("reg");
  endtask

  task automatic apply(input logic v, input logic [3:0] a, input logic ua, input logic [3:0] b,
                       input logic ub, input logic [3:0] d, input logic w, input logic l,
                       input logic f, input logic c);
    @(negedge clk);
    id_valid = v; rs1 = a; u1 = ua; rs2 = b; u2 = ub; rd = d; we = w; ld = l;
    flush = f; cnt_clr = c;
    tick();
  endtask

  initial begin
    //            v rs1 u1 rs2 u2 rd we ld fl | st m2 m3 xv cnt
    tbl[0]  = '{1, 1, 1, 2, 1, 3, 1, 0, 0,   0, 3, 3, 1, 0};
    tbl[1]  = '{1, 5, 1, 3, 1, 4, 1, 0, 0,   0, 3, 1, 1, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 3, 3, 0, 0};
    tbl[3]  = '{1, 1, 1, 2, 1, 3, 1, 0, 0,   0, 3, 3, 1, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 3, 3, 0, 0};
    tbl[5]  = '{1, 3, 1, 7, 1, 6, 1, 0, 0,   0, 0, 3, 1, 0};
    tbl[6]  = '{1, 1, 1, 2, 1, 3, 1, 0, 0,   0, 3, 3, 1, 0};
    tbl[7]  = '{1, 1, 1, 2, 1, 3, 1, 0, 0,   0, 3, 3, 1, 0};
    tbl[8]  = '{1, 3, 1, 3, 1, 8, 1, 0, 0,   0, 1, 1, 1, 0};
    tbl[9]  = '{1, 1, 1, 0, 0, 2, 1, 1, 0,   0, 3, 3, 1, 0};
    tbl[10] = '{1, 2, 1, 1, 1, 9, 1, 0, 0,   1, 3, 3, 0, 1};
    tbl[11] = '{1, 2, 1, 1, 1, 9, 1, 0, 0,   0, 0, 3, 1, 1};
    tbl[12] = '{1, 1, 1, 0, 0, 5, 1, 1, 0,   0, 3, 3, 1, 1};
    tbl[13] = '{1, 5, 1, 5, 1, 6, 1, 0, 1,   0, 3, 3, 0, 1};
    tbl[14] = '{1, 5, 1, 5, 1, 7, 1, 0, 0,   0, 3, 3, 1, 1};
    tbl[15] = '{1, 1, 1, 2, 1, 0, 1, 0, 0,   0, 3, 3, 1, 1};
    tbl[16] = '{1, 0, 1, 0, 1, 10, 1, 0, 0,  0, 3, 3, 1, 1};
    tbl[17] = '{1, 1, 1, 0, 0, 0, 1, 1, 0,   0, 3, 3, 1, 1};
    tbl[18] = '{1, 0, 1, 0, 1, 11, 1, 0, 0,  0, 3, 3, 1, 1};
    tbl[19] = '{1, 1, 1, 0, 0, 4, 1, 1, 0,   0, 3, 3, 1, 1};
    tbl[20] = '{1, 1, 1, 4, 1, 5, 1, 0, 0,   1, 3, 3, 0, 2};
    tbl[21] = '{1, 1, 1, 4, 1, 5, 1, 0, 0,   0, 3, 0, 1, 2};

    {id_valid, u1, u2, we, ld, flush, cnt_clr} = '0;
    rs1 = '0; rs2 = '0; rd = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    #3;
    chk("rst_m2", m2, 2'b11);
    chk("rst_m3", m3, 2'b11);
    chk("rst_stall", stall, 1'b0);
    chk("rst_exv", exv, 1'b0);
    chk("rst_cnt", cnt, 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      apply(tbl[i].v, tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2, tbl[i].rd, tbl[i].we,
            tbl[i].ld, tbl[i].fl, 1'b0);
      chk($sformatf("vec%0d_stall", i), act_stall, tbl[i].e_st);
      chk($sformatf("vec%0d_m2", i), m2, tbl[i].e_m2);
      chk($sformatf("vec%0d_m3", i), m3, tbl[i].e_m3);
      chk($sformatf("vec%0d_exv", i), exv, tbl[i].e_xv);
      chk($sformatf("vec%0d_cnt", i), cnt, tbl[i].e_cnt);
    end

    // reset mid-operation: a pending dependency on r3 must not survive
    apply(1, 1, 1, 2, 1, 3, 1, 0, 0, 0);
    @(negedge clk);
    id_valid = 1; rs1 = 5; u1 = 1; rs2 = 3; u2 = 1; rd = 4; we = 1; ld = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_m3", m3, 2'b11);
    chk("mid_rst_exv", exv, 1'b0);
    chk("mid_rst_cnt", cnt, 16'd0);
    chk("mid_rst_stall", stall, 1'b0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("post_rst_m3", m3, 2'b11);

    // repeated load-use pairs drive the narrow counter into saturation
    for (int i = 0; i < 20; i++) begin
      apply(1, 1, 1, 0, 0, 2, 1, 1, 0, 0);
      apply(1, 2, 1, 1, 1, 9, 1, 0, 0, 0);
      chk("lu_stall", act_stall, 1'b1);
      chk("lu_bubble", exv, 1'b0);
      apply(1, 2, 1, 1, 1, 9, 1, 0, 0, 0);
      chk("lu_fwd_m2", m2, 2'b00);
    end
    chk("sat_small", s_cnt, 4'hF);
    chk("cnt_20", cnt, 16'd20);
    apply(1, 1, 1, 0, 0, 2, 1, 1, 0, 0);
    apply(1, 2, 1, 1, 1, 9, 1, 0, 0, 1);
    chk("clr_prio_stall", act_stall, 1'b1);
    chk("clr_cnt", cnt, 16'd0);
    chk("clr_cnt_s", s_cnt, 4'd0);

    for (int i = 0; i < 800; i++)
      apply($urandom_range(3) != 0, 4'($urandom_range(7)), 1'($urandom), 4'($urandom_range(7)),
            1'($urandom), 4'($urandom_range(7)), $urandom_range(3) != 0,
            $urandom_range(2) == 0, $urandom_range(7) == 0, $urandom_range(63) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fwd_ctrl_unit.md
Name: fwd_ctrl_unit

Overview:
- Forwarding and hazard control unit for the 16-bit pipelined datapath.
- Tracks destination-register tags of instructions in EX and MEM.
- Generates the registered operand-select codes consumed by the EX-stage operand muxes: op1 mux (mux2) and op2 mux (mux3).
- Raises a one-cycle load-use stall and counts stall cycles for performance monitoring.

Parameters:
REG_AW, 4, register address width (16 architectural registers; r0 hardwired zero).
CNT_W, 16, stall counter width.

Ports:
in_clk  input  1  pipeline clock, rising edge.
in_rst_n  input  1  reset, asynchronous, active-low.
in_id_valid  input  1  valid instruction in ID this cycle.
in_id_rs1  input  REG_AW  ID source register 1 address.
in_id_rs1_used  input  1  instruction reads rs1.
in_id_rs2  input  REG_AW  ID source register 2 address.
in_id_rs2_used  input  1  instruction reads rs2.
in_id_rd  input  REG_AW  ID destination register address.
in_id_wr_en  input  1  instruction writes rd.
in_id_is_load  input  1  instruction is a memory load.
in_flush  input  1  kill the instructions in ID and EX (branch taken).
in_cnt_clr  input  1  synchronous clear of the stall counter.
out_cntrl_m2  output  2  op1 select for the EX stage.
out_cntrl_m3  output  2  op2 select for the EX stage.
out_stall  output  1  hold PC/IF/ID this cycle (combinational).
out_ex_valid  output  1  EX slot holds a real instruction.
out_stall_cnt  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Select encoding, shared by both selects:
  - 2'b11 = register-file operand (buffer2).
  - 2'b01 = ALU result in buffer3.
  - 2'b00 = writeback value from mux5.
  - 2'b10 is never driven.
- Reset (in_rst_n low, async):
  - EX and MEM slots invalid.
  - out_cntrl_m2 and out_cntrl_m3 = 2'b11.
  - out_ex_valid = 0, out_stall_cnt = 0.
  - out_stall = 0 while in reset.
- State: EX slot {v, rd, we, ld} and MEM slot {v, rd, we}, updated on every rising edge.
- Hit definition: slot X "hits" rsN when rsN_used && X.v && X.we && X.rd != 0 && X.rd == rsN.
- out_stall = in_id_valid && !in_flush && EX.ld && (EX hits rs1 || EX hits rs2).
- Every edge: MEM <= EX (MEM <= invalid if in_flush).
- Advance: when in_id_valid && !out_stall && !in_flush, EX <= ID fields, and each select is computed per operand with priority:
  - EX hit -> 01;
  - else MEM hit -> 00;
  - else 11.
- Bubble: otherwise (stall, flush, or no valid ID), EX <= invalid and both selects <= 11.
- Latency: selects are registered and valid in the cycle the instruction occupies EX; out_ex_valid mirrors EX.v.
- Load-use: exactly one stall cycle. Next cycle the load is in MEM, so the re-presented instruction advances with select 00.
- Instruction three ahead: no forwarding; the register file is write-before-read.
- r0 is never forwarded; a source of 0 always gives 11.
- in_flush has priority over stall; out_stall is forced 0 during flush.
- Counter: in_cnt_clr -> 0 (priority); else +1 per out_stall cycle, saturating at all-ones.
- Reset mid-operation: all in-flight tags are discarded; forwarding never uses pre-reset tags.

Test Plan:
- Reset -> selects 11/11, out_stall 0, out_stall_cnt 0, out_ex_valid 0. Release reset, then issue the instruction sequence below.
- Back-to-back ALU dependency: "ADD r3 <- r1,r2" then "SUB r4 <- r5,r3" -> during SUB's EX cycle out_cntrl_m3 = 01 and out_cntrl_m2 = 11.
- Distance-2 dependency: "ADD r3", NOP (valid=0), "OR r6 <- r3,r7" -> during OR's EX cycle out_cntrl_m2 = 00 and out_cntrl_m3 = 11.
- Both slots hit: "ADD r3", "ADD r3", "AND r8 <- r3,r3" -> both selects 01 (younger wins).
- Load-use: "LD r2", "ADD r9 <- r2,r1" -> out_stall = 1 for exactly one cycle; out_stall_cnt 0 -> 1; a bubble enters EX (out_ex_valid = 0); then ADD in EX with out_cntrl_m2 = 00. Repeat 65536 times -> counter holds 16'hFFFF; in_cnt_clr -> 0.
- Flush during a load-use hazard -> out_stall = 0, MEM invalid next cycle, selects 11. Also check r0: "ADD r0" then a read of r0 -> selects 11 and no stall.
